// File: rtl/call_frame_stack_pkg.sv
// Shared trap codes, FSM state type and frame-entry layout for the call frame stack.
// Frame entries are packed {pc, index, arity}, arity in the least significant bits.
package call_frame_stack_pkg;

    localparam logic [3:0] TRAP_NONE                 = 4'h0;
    localparam logic [3:0] TRAP_ILLEGAL_OP           = 4'h1;
    localparam logic [3:0] TRAP_CALL_STACK_EXHAUSTED = 4'hA;
    localparam logic [3:0] TRAP_CALL_STACK_EMPTY     = 4'hB;

    typedef enum logic {
        ST_HEALTHY = 1'b0,
        ST_TRAPPED = 1'b1
    } trap_state_e;

    function automatic int frame_width(input int pc_w, input int idx_w, input int arity_w);
        return pc_w + idx_w + arity_w;
    endfunction

endpackage

// File: rtl/call_frame_stack_frame_ram.sv
// Single-port frame store with a registered read port and an arity-only write enable.
// Read data appears one cycle after re; it holds its value while re is low.
module call_frame_stack_frame_ram #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 19,
    parameter int ARITY_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic              arity_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int ENTRIES = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [ENTRIES];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Storage is intentionally left uninitialised by reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else if (arity_we) begin
            mem_q[addr][ARITY_W-1:0] <= wdata[ARITY_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/call_frame_stack.sv
// Call/return frame stack: push on call, registered pop on ret, arity rewrite on tail.
// Popped frame is valid one cycle after ret; traps are sticky and freeze all state until reset.
module call_frame_stack
    import call_frame_stack_pkg::*;
#(
    parameter int MEM_DEPTH   = 6,
    parameter int STACK_DEPTH = 7,
    parameter int CALL_DEPTH  = 4,
    parameter int ARITY_W     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   call,
    input  logic                   ret,
    input  logic                   tail,
    input  logic [MEM_DEPTH:0]     in_pc,
    input  logic [STACK_DEPTH:0]   in_index,
    input  logic [ARITY_W-1:0]     in_arity,
    output logic [MEM_DEPTH:0]     out_pc,
    output logic [STACK_DEPTH:0]   out_index,
    output logic [ARITY_W-1:0]     out_arity,
    output logic                   out_valid,
    output logic [CALL_DEPTH:0]    depth,
    output logic                   empty,
    output logic                   full,
    output logic [3:0]             trap
);

    localparam int PC_W    = MEM_DEPTH + 1;
    localparam int IDX_W   = STACK_DEPTH + 1;
    localparam int FRAME_W = frame_width(PC_W, IDX_W, ARITY_W);

    localparam logic [CALL_DEPTH:0] DEPTH_MAX = (CALL_DEPTH+1)'(2 ** CALL_DEPTH);
    localparam logic [CALL_DEPTH:0] DEPTH_ONE = (CALL_DEPTH+1)'(1);

    trap_state_e            state_q, state_d;
    logic [3:0]             trap_q, trap_d;
    logic [CALL_DEPTH:0]    depth_q, depth_d;
    logic                   out_valid_q, out_valid_d;

    logic [1:0]             op_cnt;
    logic                   illegal;
    logic [CALL_DEPTH:0]    depth_m1;
    logic                   ram_re;
    logic                   ram_we;
    logic                   ram_arity_we;
    logic [CALL_DEPTH-1:0]  ram_addr;
    logic [FRAME_W-1:0]     ram_wdata;
    logic [FRAME_W-1:0]     ram_rdata;

    assign op_cnt    = {1'b0, call} + {1'b0, ret} + {1'b0, tail};
    assign illegal   = (op_cnt > 2'd1);
    assign depth_m1  = depth_q - DEPTH_ONE;
    assign empty     = (depth_q == '0);
    assign full      = (depth_q == DEPTH_MAX);
    assign ram_wdata = {in_pc, in_index, in_arity};

    always_comb begin
        state_d      = state_q;
        trap_d       = trap_q;
        depth_d      = depth_q;
        out_valid_d  = 1'b0;
        ram_re       = 1'b0;
        ram_we       = 1'b0;
        ram_arity_we = 1'b0;
        ram_addr     = depth_m1[CALL_DEPTH-1:0];

        // Reset on the same edge as an op discards the op, including its RAM side effects.
        if (!reset && state_q == ST_HEALTHY) begin
            if (illegal) begin
                trap_d  = TRAP_ILLEGAL_OP;
                state_d = ST_TRAPPED;
            end else if (call) begin
                if (full) begin
                    trap_d  = TRAP_CALL_STACK_EXHAUSTED;
                    state_d = ST_TRAPPED;
                end else begin
                    ram_we   = 1'b1;
                    ram_addr = depth_q[CALL_DEPTH-1:0];
                    depth_d  = depth_q + DEPTH_ONE;
                end
            end else if (ret) begin
                if (empty) begin
                    trap_d  = TRAP_CALL_STACK_EMPTY;
                    state_d = ST_TRAPPED;
                end else begin
                    ram_re      = 1'b1;
                    out_valid_d = 1'b1;
                    depth_d     = depth_m1;
                end
            end else if (tail && !empty) begin
                ram_arity_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HEALTHY;
            trap_q      <= TRAP_NONE;
            depth_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            trap_q      <= trap_d;
            depth_q     <= depth_d;
            out_valid_q <= out_valid_d;
        end
    end

    call_frame_stack_frame_ram #(
        .ADDR_W  (CALL_DEPTH),
        .DATA_W  (FRAME_W),
        .ARITY_W (ARITY_W)
    ) u_frame_ram (
        .clk      (clk),
        .reset    (reset),
        .re       (ram_re),
        .we       (ram_we),
        .arity_we (ram_arity_we),
        .addr     (ram_addr),
        .wdata    (ram_wdata),
        .rdata    (ram_rdata)
    );

    assign out_pc    = ram_rdata[FRAME_W-1 -: PC_W];
    assign out_index = ram_rdata[ARITY_W +: IDX_W];
    assign out_arity = ram_rdata[ARITY_W-1:0];
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_call_frame_stack.sv
// Directed vector table plus hand-written trap sequences for call_frame_stack (CALL_DEPTH=2).
module tb_call_frame_stack;

    localparam int MEM_DEPTH   = 6;
    localparam int STACK_DEPTH = 7;
    localparam int CALL_DEPTH  = 2;
    localparam int ARITY_W     = 2;

    localparam logic [3:0] T_NONE  = 4'h0;
    localparam logic [3:0] T_ILL   = 4'h1;
    localparam logic [3:0] T_EXH   = 4'hA;
    localparam logic [3:0] T_EMPTY = 4'hB;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  call = 1'b0;
    logic                  ret = 1'b0;
    logic                  tail = 1'b0;
    logic [MEM_DEPTH:0]    in_pc = '0;
    logic [STACK_DEPTH:0]  in_index = '0;
    logic [ARITY_W-1:0]    in_arity = '0;
    logic [MEM_DEPTH:0]    out_pc;
    logic [STACK_DEPTH:0]  out_index;
    logic [ARITY_W-1:0]    out_arity;
    logic                  out_valid;
    logic [CALL_DEPTH:0]   depth;
    logic                  empty;
    logic                  full;
    logic [3:0]            trap;

    int n_checks = 0;
    int n_fail   = 0;

    call_frame_stack #(
        .MEM_DEPTH   (MEM_DEPTH),
        .STACK_DEPTH (STACK_DEPTH),
        .CALL_DEPTH  (CALL_DEPTH),
        .ARITY_W     (ARITY_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .ret       (ret),
        .tail      (tail),
        .in_pc     (in_pc),
        .in_index  (in_index),
        .in_arity  (in_arity),
        .out_pc    (out_pc),
        .out_index (out_index),
        .out_arity (out_arity),
        .out_valid (out_valid),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       c;
        logic       rt;
        logic       t;
        int         pc;
        int         idx;
        int         ar;
        logic       ev;
        int         epc;
        int         eidx;
        int         ear;
        int         edep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic rt, input logic t,
                       input int pc, input int idx, input int ar,
                       input logic ev, input int epc, input int eidx, input int ear,
                       input int edep);
        vec_t v;
        v.r = r; v.c = c; v.rt = rt; v.t = t;
        v.pc = pc; v.idx = idx; v.ar = ar;
        v.ev = ev; v.epc = epc; v.eidx = eidx; v.ear = ear; v.edep = edep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic rt, input logic t,
                         input int pc, input int idx, input int ar);
        reset    = r;
        call     = c;
        ret      = rt;
        tail     = t;
        in_pc    = pc[MEM_DEPTH:0];
        in_index = idx[STACK_DEPTH:0];
        in_arity = ar[ARITY_W-1:0];
    endtask

    // Apply inputs for one rising edge, then sample outputs 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_op(input logic r, input logic c, input logic rt, input logic t,
                         input int pc);
        drive(r, c, rt, t, pc, 0, 0);
        tick();
    endtask

    initial begin
        // reset, call, ret
        add(1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0);
        add(0, 1, 0, 0, 33, 0, 1,  0,  0, 0, 0,  1);
        add(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  1);
        add(0, 0, 1, 0,  0, 0, 0,  1, 33, 0, 1,  0);
        add(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0);
        // fill to full, then back-to-back pops
        add(0, 1, 0, 0, 10, 1, 0,  0,  0, 0, 0,  1);
        add(0, 1, 0, 0, 11, 2, 1,  0,  0, 0, 0,  2);
        add(0, 1, 0, 0, 12, 3, 2,  0,  0, 0, 0,  3);
        add(0, 1, 0, 0, 13, 4, 3,  0,  0, 0, 0,  4);
        add(0, 0, 1, 0,  0, 0, 0,  1, 13, 4, 3,  3);
        add(0, 0, 1, 0,  0, 0, 0,  1, 12, 3, 2,  2);
        add(0, 0, 1, 0,  0, 0, 0,  1, 11, 2, 1,  1);
        add(0, 0, 1, 0,  0, 0, 0,  1, 10, 1, 0,  0);
        add(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0);
        // tail call rewrites arity only; tail on empty is a no-op
        add(0, 1, 0, 0, 20, 5, 0,  0,  0, 0, 0,  1);
        add(0, 0, 0, 1, 99, 9, 2,  0,  0, 0, 0,  1);
        add(0, 0, 1, 0,  0, 0, 0,  1, 20, 5, 2,  0);
        add(0, 0, 0, 1,  0, 0, 3,  0,  0, 0, 0,  0);
        // call right after ret reuses the freed slot
        add(0, 1, 0, 0, 40, 6, 1,  0,  0, 0, 0,  1);
        add(0, 1, 0, 0, 41, 7, 2,  0,  0, 0, 0,  2);
        add(0, 0, 1, 0,  0, 0, 0,  1, 41, 7, 2,  1);
        add(0, 1, 0, 0, 42, 8, 3,  0,  0, 0, 0,  2);
        add(0, 0, 1, 0,  0, 0, 0,  1, 42, 8, 3,  1);
        add(0, 0, 1, 0,  0, 0, 0,  1, 40, 6, 1,  0);
        add(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].c, vecs[i].rt, vecs[i].t,
                  vecs[i].pc, vecs[i].idx, vecs[i].ar);
            tick();
            chk($sformatf("v%0d depth", i), int'(depth), vecs[i].edep);
            chk($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].edep == 0));
            chk($sformatf("v%0d full", i), int'(full), int'(vecs[i].edep == 4));
            chk($sformatf("v%0d trap", i), int'(trap), int'(T_NONE));
            chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d out_pc", i), int'(out_pc), vecs[i].epc);
                chk($sformatf("v%0d out_index", i), int'(out_index), vecs[i].eidx);
                chk($sformatf("v%0d out_arity", i), int'(out_arity), vecs[i].ear);
            end
            if (i == 0) begin
                chk("reset out_pc", int'(out_pc), 0);
                chk("reset out_index", int'(out_index), 0);
                chk("reset out_arity", int'(out_arity), 0);
            end
        end

        // exhaustion trap is sticky, ignores ret, cleared by reset
        for (int i = 0; i < 4; i++) do_op(0, 1, 0, 0, 50 + i);
        chk("exh full", int'(full), 1);
        do_op(0, 1, 0, 0, 60);
        chk("exh trap", int'(trap), int'(T_EXH));
        chk("exh depth", int'(depth), 4);
        do_op(0, 0, 1, 0, 0);
        chk("exh ret valid", int'(out_valid), 0);
        chk("exh ret depth", int'(depth), 4);
        chk("exh ret trap", int'(trap), int'(T_EXH));
        do_op(1, 0, 0, 0, 0);
        chk("exh reset trap", int'(trap), int'(T_NONE));
        chk("exh reset depth", int'(depth), 0);

        // ret on empty traps; later call is ignored
        do_op(0, 0, 1, 0, 0);
        chk("empty trap", int'(trap), int'(T_EMPTY));
        chk("empty valid", int'(out_valid), 0);
        do_op(0, 1, 0, 0, 7);
        chk("empty call depth", int'(depth), 0);
        chk("empty call trap", int'(trap), int'(T_EMPTY));
        do_op(1, 0, 0, 0, 0);

        // simultaneous ops are illegal and leave depth alone
        do_op(0, 1, 0, 0, 5);
        do_op(0, 1, 1, 0, 6);
        chk("illegal trap", int'(trap), int'(T_ILL));
        chk("illegal depth", int'(depth), 1);
        chk("illegal valid", int'(out_valid), 0);
        do_op(1, 0, 0, 0, 0);
        do_op(0, 0, 1, 1, 0);
        chk("illegal ret+tail trap", int'(trap), int'(T_ILL));
        do_op(1, 0, 0, 0, 0);

        // reset on the same edge as call discards the call
        do_op(1, 1, 0, 0, 9);
        chk("reset+call depth", int'(depth), 0);
        chk("reset+call trap", int'(trap), int'(T_NONE));
        do_op(0, 0, 0, 0, 0);
        chk("reset+call idle depth", int'(depth), 0);
        chk("reset+call empty", int'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
